// File: rtl/fpu_seq_ctrl.sv
// EX-stage FPU sequencer: launches multi-cycle FP ops, stalls EX until the result
// is ready, and arbitrates the shared 24x24 multiplier between FMULS and integer MUL.
module fpu_seq_ctrl #(
  parameter int         TIMEOUT     = 64,
  parameter int         CNT_W       = 7,
  parameter logic [4:0] ALU_FMULS   = 5'h18,
  parameter logic [4:0] ALU_FADDS   = 5'h19,
  parameter logic [4:0] ALU_FSUBS   = 5'h1a,
  parameter logic [4:0] ALU_FCVTSW  = 5'h1b,
  parameter logic [4:0] ALU_FCVTSWU = 5'h1c,
  parameter logic [4:0] ALU_FCVTWS  = 5'h1d,
  parameter logic [4:0] ALU_FCVTWUS = 5'h1e
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ex_valid_i,
  input  logic [4:0] ex_alu_func_i,
  input  logic       flush_i,
  input  logic       fpu_busy_i,
  input  logic       int_mul_req_i,
  output logic       fpu_new_input_o,
  output logic       mul_sel_fpu_o,
  output logic       int_mul_grant_o,
  output logic       ex_stall_o,
  output logic       fpu_done_o,
  output logic       fpu_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_WAIT} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_INT, OWN_FPU} owner_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d, grant;
  logic             lastFpu_q, lastFpu_d;
  logic             fpuErr_q, fpuErr_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;

  logic isMul, isMc, isSc;
  logic fpuReq, fpuDone, fpuTimeout, flushAbort, fpuRelease, ownerFree;
  logic newInput, stall, done;

  assign isMul = (ex_alu_func_i == ALU_FMULS);
  assign isMc  = isMul || (ex_alu_func_i == ALU_FADDS) || (ex_alu_func_i == ALU_FSUBS);
  assign isSc  = (ex_alu_func_i == ALU_FCVTSW)  || (ex_alu_func_i == ALU_FCVTSWU) ||
                 (ex_alu_func_i == ALU_FCVTWS)  || (ex_alu_func_i == ALU_FCVTWUS);

  assign flushAbort = flush_i && (state_q != S_IDLE);
  assign fpuDone    = (state_q == S_WAIT) && !flush_i && (waitCnt_q >= CNT_ONE) && !fpu_busy_i;
  assign fpuTimeout = (state_q == S_WAIT) && !flush_i && (waitCnt_q == CNT_MAX) && fpu_busy_i;
  assign fpuReq     = !flush_i && (((state_q == S_IDLE) && ex_valid_i && isMul) ||
                                   ((state_q == S_ARB) && (owner_q != OWN_FPU)));
  assign fpuRelease = (owner_q == OWN_FPU) && (fpuDone || fpuTimeout || flushAbort);

  // A releasing owner frees the multiplier this cycle so the waiter is granted back-to-back.
  assign ownerFree  = (owner_q == OWN_NONE) || ((owner_q == OWN_INT) && !int_mul_req_i) ||
                      fpuRelease;

  always_comb begin
    grant = OWN_NONE;
    if (int_mul_req_i && fpuReq) grant = lastFpu_q ? OWN_INT : OWN_FPU;
    else if (int_mul_req_i)      grant = OWN_INT;
    else if (fpuReq)             grant = OWN_FPU;
  end

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    owner_d   = owner_q;
    lastFpu_d = lastFpu_q;
    fpuErr_d  = fpuErr_q;
    newInput  = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;

    if (ownerFree) begin
      owner_d = grant;
      if (grant != OWN_NONE) lastFpu_d = (grant == OWN_FPU);
    end

    case (state_q)
      S_IDLE: begin
        if (ex_valid_i && !flush_i) begin
          if (isSc) begin
            done = 1'b1;
          end else if (isMc) begin
            stall = 1'b1;
            // FMULS launches directly only when it takes an idle multiplier this cycle.
            if (!isMul || ((owner_q == OWN_NONE) && (grant == OWN_FPU))) begin
              newInput  = 1'b1;
              waitCnt_d = '0;
              state_d   = S_WAIT;
            end else begin
              state_d = S_ARB;
            end
          end
        end
      end
      S_ARB: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
          if (owner_q == OWN_FPU) begin
            newInput  = 1'b1;
            waitCnt_d = '0;
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (fpuDone) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (fpuTimeout) begin
          fpuErr_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          stall     = 1'b1;
          waitCnt_d = (waitCnt_q == CNT_MAX) ? waitCnt_q : waitCnt_q + CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      waitCnt_q <= '0;
      owner_q   <= OWN_NONE;
      lastFpu_q <= 1'b0;
      fpuErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      owner_q   <= owner_d;
      lastFpu_q <= lastFpu_d;
      fpuErr_q  <= fpuErr_d;
    end
  end

  // Outputs are forced low while reset is held so a pending decode cannot leak through.
  assign fpu_new_input_o = newInput && !rst_i;
  assign ex_stall_o      = stall && !rst_i;
  assign fpu_done_o      = done && !rst_i;
  assign mul_sel_fpu_o   = (owner_q == OWN_FPU) && !rst_i;
  assign int_mul_grant_o = (owner_q == OWN_INT) && !rst_i;
  assign fpu_err_o       = fpuErr_q && !rst_i;

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Cycle-accurate bench for fpu_seq_ctrl: vector table plus hand-written sequences,
// with expected outputs queued at drive time and popped at the sampling edge.
module tb_fpu_seq_ctrl;

  localparam logic [4:0] F_MULS  = 5'h18;
  localparam logic [4:0] F_ADDS  = 5'h19;
  localparam logic [4:0] F_SUBS  = 5'h1a;
  localparam logic [4:0] F_CVTWS = 5'h1d;
  localparam logic [4:0] F_NOP   = 5'h03;

  logic       clk = 1'b0;
  logic       rst, exValid, flush, busy, intReq;
  logic [4:0] func;
  logic       newInput, mulSel, intGrant, stall, done, err;

  typedef struct packed {
    logic       rst;
    logic       exValid;
    logic [4:0] func;
    logic       flush;
    logic       busy;
    logic       intReq;
  } in_t;

  // exp bit order: {new_input, mul_sel_fpu, int_mul_grant, ex_stall, fpu_done, fpu_err}
  typedef struct packed {
    in_t        in;
    logic [5:0] exp;
  } vec_t;

  vec_t       vecs[$];
  string      vecNames[$];
  logic [5:0] expQ[$];
  string      nameQ[$];
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  fpu_seq_ctrl #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ex_valid_i      (exValid),
    .ex_alu_func_i   (func),
    .flush_i         (flush),
    .fpu_busy_i      (busy),
    .int_mul_req_i   (intReq),
    .fpu_new_input_o (newInput),
    .mul_sel_fpu_o   (mulSel),
    .int_mul_grant_o (intGrant),
    .ex_stall_o      (stall),
    .fpu_done_o      (done),
    .fpu_err_o       (err)
  );

  function automatic vec_t mk(input logic r, input logic ev, input logic [4:0] f,
                              input logic fl, input logic b, input logic ir,
                              input logic [5:0] e);
    vec_t v;
    v.in.rst     = r;
    v.in.exValid = ev;
    v.in.func    = f;
    v.in.flush   = fl;
    v.in.busy    = b;
    v.in.intReq  = ir;
    v.exp        = e;
    return v;
  endfunction

  function automatic void add(input string n, input vec_t v);
    vecs.push_back(v);
    vecNames.push_back(n);
  endfunction

  task automatic applyStimulus(input vec_t v, input string n);
    @(posedge clk);
    #1;
    rst     = v.in.rst;
    exValid = v.in.exValid;
    func    = v.in.func;
    flush   = v.in.flush;
    busy    = v.in.busy;
    intReq  = v.in.intReq;
    expQ.push_back(v.exp);
    nameQ.push_back(n);
  endtask

  task automatic checkOutput();
    logic [5:0] act;
    logic [5:0] want;
    string      n;
    @(negedge clk);
    act  = {newInput, mulSel, intGrant, stall, done, err};
    want = expQ.pop_front();
    n    = nameQ.pop_front();
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s: new/sel/grant/stall/done/err got %b, expected %b", n, act, want);
    end
  endtask

  task automatic step(input vec_t v, input string n);
    applyStimulus(v, n);
    checkOutput();
  endtask

  initial begin
    rst = 1'b1; exValid = 1'b0; func = F_NOP; flush = 1'b0; busy = 1'b0; intReq = 1'b0;

    // reset state
    add("reset0",      mk(1, 0, F_NOP,   0, 0, 0, 6'b000000));
    add("reset1",      mk(1, 0, F_NOP,   0, 0, 0, 6'b000000));
    // FADDS, busy three cycles after launch
    add("fadds_t0",    mk(0, 1, F_ADDS,  0, 0, 0, 6'b100100));
    add("fadds_t1",    mk(0, 1, F_ADDS,  0, 1, 0, 6'b000100));
    add("fadds_t2",    mk(0, 1, F_ADDS,  0, 1, 0, 6'b000100));
    add("fadds_t3",    mk(0, 1, F_ADDS,  0, 1, 0, 6'b000100));
    add("fadds_t4",    mk(0, 1, F_ADDS,  0, 0, 0, 6'b000010));
    add("fadds_t5",    mk(0, 0, F_NOP,   0, 0, 0, 6'b000000));
    // single-cycle conversion
    add("fcvtws",      mk(0, 1, F_CVTWS, 0, 0, 0, 6'b000010));
    add("fcvtws_idle", mk(0, 0, F_NOP,   0, 0, 0, 6'b000000));
    // tie with last owner INT: FPU wins and launches at once
    add("tieA_launch", mk(0, 1, F_MULS,  0, 0, 1, 6'b100100));
    add("tieA_wait",   mk(0, 1, F_MULS,  0, 1, 0, 6'b010100));
    add("tieA_done",   mk(0, 1, F_MULS,  0, 0, 0, 6'b010010));
    add("tieA_idle",   mk(0, 0, F_NOP,   0, 0, 0, 6'b000000));
    // tie with last owner FPU: INT wins, FMULS parks in ARB
    add("tieB_arb",    mk(0, 1, F_MULS,  0, 0, 1, 6'b000100));
    add("tieB_int1",   mk(0, 1, F_MULS,  0, 0, 1, 6'b001100));
    add("tieB_int2",   mk(0, 1, F_MULS,  0, 0, 1, 6'b001100));
    add("tieB_drop",   mk(0, 1, F_MULS,  0, 0, 0, 6'b001100));
    add("tieB_launch", mk(0, 1, F_MULS,  0, 0, 0, 6'b110100));
    add("tieB_wait",   mk(0, 1, F_MULS,  0, 1, 0, 6'b010100));
    add("tieB_done",   mk(0, 1, F_MULS,  0, 0, 0, 6'b010010));
    add("tieB_idle",   mk(0, 0, F_NOP,   0, 0, 0, 6'b000000));
    // integer unit holds the multiplier for five cycles, FMULS arrives at cycle 2
    add("hold_c0",     mk(0, 0, F_NOP,   0, 0, 1, 6'b000000));
    add("hold_c1",     mk(0, 0, F_NOP,   0, 0, 1, 6'b001000));
    add("hold_c2",     mk(0, 1, F_MULS,  0, 0, 1, 6'b001100));
    add("hold_c3",     mk(0, 1, F_MULS,  0, 0, 1, 6'b001100));
    add("hold_c4",     mk(0, 1, F_MULS,  0, 0, 1, 6'b001100));
    add("hold_c5",     mk(0, 1, F_MULS,  0, 0, 0, 6'b001100));
    add("hold_c6",     mk(0, 1, F_MULS,  0, 0, 0, 6'b110100));
    add("hold_c7",     mk(0, 1, F_MULS,  0, 1, 0, 6'b010100));
    add("hold_c8",     mk(0, 1, F_MULS,  0, 0, 0, 6'b010010));
    add("hold_c9",     mk(0, 0, F_NOP,   0, 0, 0, 6'b000000));
    // FSUBS with one busy cycle, a non-FP func, and a flushed FADDS in IDLE
    add("fsubs_t0",    mk(0, 1, F_SUBS,  0, 0, 0, 6'b100100));
    add("fsubs_t1",    mk(0, 1, F_SUBS,  0, 1, 0, 6'b000100));
    add("fsubs_t2",    mk(0, 1, F_SUBS,  0, 0, 0, 6'b000010));
    add("fsubs_idle",  mk(0, 0, F_NOP,   0, 0, 0, 6'b000000));
    add("nonfp",       mk(0, 1, F_NOP,   0, 0, 0, 6'b000000));
    add("flush_idle",  mk(0, 1, F_ADDS,  1, 0, 0, 6'b000000));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], vecNames[i]);

    // flush of FMULS in WAIT at wait_cnt=2
    step(mk(0, 1, F_MULS, 0, 0, 0, 6'b100100), "flushW_launch");
    step(mk(0, 0, F_NOP,  0, 1, 0, 6'b010100), "flushW_cnt0");
    step(mk(0, 0, F_NOP,  0, 1, 0, 6'b010100), "flushW_cnt1");
    step(mk(0, 0, F_NOP,  1, 1, 0, 6'b010000), "flushW_cnt2");
    step(mk(0, 0, F_NOP,  0, 0, 0, 6'b000000), "flushW_idle");

    // fpu_busy stuck high: timeout at wait_cnt=7, sticky error
    step(mk(0, 1, F_ADDS, 0, 0, 0, 6'b100100), "tmo_launch");
    for (int i = 0; i < 7; i++)
      step(mk(0, 0, F_NOP, 0, 1, 0, 6'b000100), $sformatf("tmo_cnt%0d", i));
    step(mk(0, 0, F_NOP,   0, 1, 0, 6'b000000), "tmo_cnt7");
    for (int i = 0; i < 3; i++)
      step(mk(0, 0, F_NOP, 0, 0, 0, 6'b000001), $sformatf("tmo_sticky%0d", i));
    step(mk(0, 1, F_CVTWS, 0, 0, 0, 6'b000011), "tmo_fcvt");
    step(mk(0, 0, F_NOP,   0, 0, 0, 6'b000001), "tmo_sticky3");

    // reset mid-WAIT aborts silently and clears the error
    step(mk(0, 1, F_ADDS, 0, 0, 0, 6'b100101), "rstW_launch");
    step(mk(0, 0, F_NOP,  0, 1, 0, 6'b000101), "rstW_cnt0");
    step(mk(0, 0, F_NOP,  0, 1, 0, 6'b000101), "rstW_cnt1");
    step(mk(1, 0, F_NOP,  0, 1, 0, 6'b000000), "rstW_assert");
    step(mk(0, 0, F_NOP,  0, 1, 0, 6'b000000), "rstW_after");
    step(mk(0, 0, F_NOP,  0, 0, 0, 6'b000000), "rstW_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
